// File: rtl/go_board_pkg.sv
// Shared board definitions: cell and response encodings plus the placer FSM state type.
package go_board_pkg;

    localparam int unsigned CELL_BITS = 2;
    localparam int unsigned RESP_BITS = 2;

    localparam logic [CELL_BITS-1:0] CELL_EMPTY = 2'd0;
    localparam logic [CELL_BITS-1:0] CELL_BLACK = 2'd1;
    localparam logic [CELL_BITS-1:0] CELL_WHITE = 2'd2;

    localparam logic [RESP_BITS-1:0] RESP_OK        = 2'd0;
    localparam logic [RESP_BITS-1:0] RESP_OCCUPIED  = 2'd1;
    localparam logic [RESP_BITS-1:0] RESP_BAD_COLOR = 2'd2;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_REJECT = 3'd4
    } placer_state_e;

endpackage

// File: rtl/stone_placer.sv
// Move-commit controller and sole writer of the 2-bit-per-cell board RAM.
// Optional stone counters are built when STONE_COUNT_EN is defined.
module stone_placer
    import go_board_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 2,
    parameter int unsigned EDGE_ADDR_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_req,
    input  logic                          mv_valid,
    output logic                          mv_ready,
    input  logic [EDGE_ADDR_BITS-1:0]     mv_row,
    input  logic [EDGE_ADDR_BITS-1:0]     mv_col,
    input  logic [DATA_BITS-1:0]          mv_color,
    output logic                          resp_valid,
    output logic [RESP_BITS-1:0]          resp_code,
    output logic                          busy,
    output logic                          ram_wr_en,
    output logic [2*EDGE_ADDR_BITS-1:0]   ram_wr_addr,
    output logic [DATA_BITS-1:0]          ram_wr_data,
    output logic [2*EDGE_ADDR_BITS-1:0]   ram_rd_addr,
    input  logic [DATA_BITS-1:0]          ram_rd_data
`ifdef STONE_COUNT_EN
    ,
    output logic [2*EDGE_ADDR_BITS:0]     black_count,
    output logic [2*EDGE_ADDR_BITS:0]     white_count
`endif
);

    localparam int unsigned ADDR_BITS = 2 * EDGE_ADDR_BITS;
    localparam int unsigned CNT_BITS  = ADDR_BITS + 1;

    placer_state_e state_q, state_d;

    logic [ADDR_BITS-1:0] clr_cnt_q;
    logic [ADDR_BITS-1:0] mv_addr_q;
    logic [DATA_BITS-1:0] mv_color_q;
    logic [RESP_BITS-1:0] rej_code_q;

    logic color_bad;
    logic cell_occupied;
    logic clear_last;
    logic mv_accept;
    logic clear_start;

    assign color_bad     = (mv_color_q != DATA_BITS'(CELL_BLACK)) &&
                           (mv_color_q != DATA_BITS'(CELL_WHITE));
    assign cell_occupied = (ram_rd_data != DATA_BITS'(CELL_EMPTY));
    assign clear_last    = &clr_cnt_q;
    assign clear_start   = (state_q == ST_IDLE) && clear_req;
    assign mv_accept     = (state_q == ST_IDLE) && !clear_req && mv_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (clear_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (mv_valid) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (color_bad || cell_occupied) begin
                    state_d = ST_REJECT;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE:  state_d = ST_IDLE;
            ST_REJECT: state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
        endcase
    end

    // Clear sweep counter, latched move and stored reject reason
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q  <= '0;
            mv_addr_q  <= '0;
            mv_color_q <= '0;
            rej_code_q <= RESP_OK;
        end else begin
            if (state_q == ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + ADDR_BITS'(1);
            end else if (clear_start) begin
                clr_cnt_q <= '0;
            end
            if (mv_accept) begin
                mv_addr_q  <= {mv_row, mv_col};
                mv_color_q <= mv_color;
            end
            if (state_q == ST_CHECK) begin
                rej_code_q <= color_bad ? RESP_BAD_COLOR : RESP_OCCUPIED;
            end
        end
    end

`ifdef STONE_COUNT_EN
    // Stone tallies; wiped whenever a clear begins
    always_ff @(posedge clk) begin
        if (rst || clear_start) begin
            black_count <= '0;
            white_count <= '0;
        end else if (state_q == ST_WRITE) begin
            if (mv_color_q == DATA_BITS'(CELL_BLACK)) begin
                black_count <= black_count + CNT_BITS'(1);
            end else begin
                white_count <= white_count + CNT_BITS'(1);
            end
        end
    end
`endif

    assign ram_rd_addr = mv_addr_q;

    // Moore output decode; held at reset values while rst is high
    always_comb begin
        mv_ready    = 1'b0;
        busy        = 1'b1;
        resp_valid  = 1'b0;
        resp_code   = RESP_OK;
        ram_wr_en   = 1'b0;
        ram_wr_addr = mv_addr_q;
        ram_wr_data = mv_color_q;
        if (!rst) begin
            unique case (state_q)
                ST_CLEAR: begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = clr_cnt_q;
                    ram_wr_data = DATA_BITS'(CELL_EMPTY);
                end
                ST_IDLE: begin
                    mv_ready = 1'b1;
                    busy     = 1'b0;
                end
                ST_WRITE: begin
                    ram_wr_en  = 1'b1;
                    resp_valid = 1'b1;
                    resp_code  = RESP_OK;
                end
                ST_REJECT: begin
                    resp_valid = 1'b1;
                    resp_code  = rej_code_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stone_placer.sv
// Self-checking bench for stone_placer: board RAM, cycle-level reference model and directed moves.
module tb_stone_placer;
    import go_board_pkg::*;

    localparam int unsigned EAB = 3;
    localparam int unsigned AB  = 2 * EAB;
    localparam int          N   = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear_req;
    logic            mv_valid;
    logic            mv_ready;
    logic [EAB-1:0]  mv_row;
    logic [EAB-1:0]  mv_col;
    logic [1:0]      mv_color;
    logic            resp_valid;
    logic [1:0]      resp_code;
    logic            busy;
    logic            ram_wr_en;
    logic [AB-1:0]   ram_wr_addr;
    logic [1:0]      ram_wr_data;
    logic [AB-1:0]   ram_rd_addr;
    logic [1:0]      ram_rd_data;
`ifdef STONE_COUNT_EN
    logic [AB:0]     black_count;
    logic [AB:0]     white_count;
`endif

    always #5 clk = ~clk;

    stone_placer #(.DATA_BITS(2), .EDGE_ADDR_BITS(EAB)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_row(mv_row), .mv_col(mv_col), .mv_color(mv_color),
        .resp_valid(resp_valid), .resp_code(resp_code), .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
`ifdef STONE_COUNT_EN
        , .black_count(black_count), .white_count(white_count)
`endif
    );

    // Board RAM with combinational read
    logic [1:0] mem [0:N-1];
    always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    assign ram_rd_data = mem[ram_rd_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: clear progress, move age, board contents, stone tallies
    int clr_addr = -1;
    int mv_age   = -1;
    int m_addr, m_color, m_code;
    int m_board [N];
    int m_black = 0, m_white = 0;
    bit started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            clr_addr = 0; mv_age = -1; m_black = 0; m_white = 0;
        end else if (clr_addr >= 0) begin
            clr_addr++;
            if (clr_addr == N) begin
                clr_addr = -1;
                for (int i = 0; i < N; i++) m_board[i] = 0;
            end
        end else if (mv_age == 1) begin
            mv_age = 2;
            if (m_color != 1 && m_color != 2) m_code = 2;
            else if (m_board[m_addr] != 0)    m_code = 1;
            else                              m_code = 0;
        end else if (mv_age == 2) begin
            mv_age = -1;
            if (m_code == 0) begin
                m_board[m_addr] = m_color;
                if (m_color == 1) m_black++; else m_white++;
            end
        end else if (clear_req) begin
            clr_addr = 0; m_black = 0; m_white = 0;
        end else if (mv_valid) begin
            m_addr  = int'(mv_row) * 8 + int'(mv_col);
            m_color = int'(mv_color);
            mv_age  = 1;
        end
    end

    // Event log for directed expectations
    int wr_pulses = 0, first_wr_addr = -1, last_wr_addr = -1, last_wr_data = -1;
    int resp_seen = 0, last_code = -1;

    task automatic clear_log();
        wr_pulses = 0; first_wr_addr = -1; last_wr_addr = -1; last_wr_data = -1;
        resp_seen = 0; last_code = -1;
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                chk("rst_ready", int'(mv_ready), 0);
                chk("rst_busy", int'(busy), 1);
                chk("rst_resp_valid", int'(resp_valid), 0);
                chk("rst_resp_code", int'(resp_code), 0);
                chk("rst_wr_en", int'(ram_wr_en), 0);
            end else begin
                automatic bit idle   = (clr_addr < 0) && (mv_age < 0);
                automatic bit exp_wr = (clr_addr >= 0) || (mv_age == 2 && m_code == 0);
                chk("mv_ready", int'(mv_ready), int'(idle));
                chk("busy", int'(busy), int'(!idle));
                chk("resp_valid", int'(resp_valid), int'(mv_age == 2));
                chk("wr_en", int'(ram_wr_en), int'(exp_wr));
                if (exp_wr) begin
                    chk("wr_addr", int'(ram_wr_addr), (clr_addr >= 0) ? clr_addr : m_addr);
                    chk("wr_data", int'(ram_wr_data), (clr_addr >= 0) ? 0 : m_color);
                end
                if (mv_age == 2) chk("resp_code", int'(resp_code), m_code);
                if (mv_age == 1) chk("rd_addr", int'(ram_rd_addr), m_addr);
            end
`ifdef STONE_COUNT_EN
            chk("black_count", int'(black_count), m_black);
            chk("white_count", int'(white_count), m_white);
`endif
            if (!rst && ram_wr_en) begin
                if (wr_pulses == 0) first_wr_addr = int'(ram_wr_addr);
                wr_pulses++;
                last_wr_addr = int'(ram_wr_addr);
                last_wr_data = int'(ram_wr_data);
            end
            if (!rst && resp_valid) begin
                resp_seen++;
                last_code = int'(resp_code);
            end
        end
    end

    // Waits for mv_ready, sampled 1 time unit after each edge; returns cycles waited
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!mv_ready && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic do_move(input int row, input int col, input int color,
                           input int exp_code, input int exp_wr, input string tag);
        int cyc;
        wait_ready(cyc);
        chk({tag, "_ready_timeout"}, int'(mv_ready), 1);
        clear_log();
        mv_valid = 1'b1;
        mv_row   = EAB'(row);
        mv_col   = EAB'(col);
        mv_color = 2'(color);
        @(posedge clk); #1;
        mv_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_resp_count"}, resp_seen, 1);
        chk({tag, "_code"}, last_code, exp_code);
        chk({tag, "_wr_pulses"}, wr_pulses, exp_wr);
        chk({tag, "_ready_back"}, int'(mv_ready), 1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; clear_req = 1'b0; mv_valid = 1'b0;
        mv_row = '0; mv_col = '0; mv_color = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_log();

        // Power-up sweep
        wait_ready(cyc);
        chk("init_ready_latency", cyc, 64);
        chk("init_wr_pulses", wr_pulses, 64);
        chk("init_first_addr", first_wr_addr, 0);
        chk("init_last_addr", last_wr_addr, 63);

        do_move(2, 5, 1, 0, 1, "black_2_5");
        chk("black_2_5_addr", last_wr_addr, 21);
        chk("black_2_5_data", last_wr_data, 1);
`ifdef STONE_COUNT_EN
        chk("black_2_5_bcount", int'(black_count), 1);
`endif
        do_move(2, 5, 2, 1, 0, "white_occupied");
`ifdef STONE_COUNT_EN
        chk("white_occupied_wcount", int'(white_count), 0);
`endif
        do_move(0, 0, 3, 2, 0, "color3_empty");
        do_move(2, 5, 0, 2, 0, "color0_occupied");
        do_move(7, 7, 2, 0, 1, "white_7_7");
        chk("white_7_7_addr", last_wr_addr, 63);
        chk("white_7_7_data", last_wr_data, 2);

        // Clear request wins over a simultaneous move
        wait_ready(cyc);
        clear_log();
        clear_req = 1'b1; mv_valid = 1'b1;
        mv_row = 3'd1; mv_col = 3'd1; mv_color = 2'd1;
        @(posedge clk); #1;
        clear_req = 1'b0; mv_valid = 1'b0;
        wait_ready(cyc);
        chk("clr_ready_latency", cyc, 64);
        chk("clr_wr_pulses", wr_pulses, 64);
        chk("clr_no_resp", resp_seen, 0);
`ifdef STONE_COUNT_EN
        chk("clr_bcount", int'(black_count), 0);
        chk("clr_wcount", int'(white_count), 0);
`endif
        do_move(2, 5, 2, 0, 1, "after_clear");

        // Reset in the middle of a sweep
        wait_ready(cyc);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        cyc = 0;
        while (!(ram_wr_en && ram_wr_addr == AB'(30)) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midclr_reach_30", int'(ram_wr_addr), 30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
        wait_ready(cyc);
        chk("midclr_ready_latency", cyc, 64);
        chk("midclr_wr_pulses", wr_pulses, 64);
        chk("midclr_first_addr", first_wr_addr, 0);
        chk("midclr_last_addr", last_wr_addr, 63);
        do_move(2, 5, 1, 0, 1, "post_reset_move");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
